// File: rtl/myvision_kbd_pkg.sv
// Shared definitions for the MyVision key matrix: hold-tick default,
// matrix position type, joystick rows and the PS/2 scancode table.
package myvision_kbd_pkg;

    // About 10 ms of clk_sys at 35.79 MHz.
    localparam int TICK_DIV_DEFAULT = 357955;

    // Matrix rows driven by the two joysticks (cols 0..4 = right, left, down, up, fire).
    localparam int JOY0_ROW = 6;
    localparam int JOY1_ROW = 7;

    typedef struct packed {
        logic       hit;
        logic [2:0] row;
        logic [2:0] col;
    } key_pos_t;

    // Maps {extended, scancode} to a matrix position; unmapped codes return hit=0.
    function automatic key_pos_t ps2_to_pos(input logic [8:0] code);
        key_pos_t pos;
        pos = '0;
        case (code)
            // Row 0: digits 1..8
            9'h016: pos = {1'b1, 3'd0, 3'd0};
            9'h01E: pos = {1'b1, 3'd0, 3'd1};
            9'h026: pos = {1'b1, 3'd0, 3'd2};
            9'h025: pos = {1'b1, 3'd0, 3'd3};
            9'h02E: pos = {1'b1, 3'd0, 3'd4};
            9'h036: pos = {1'b1, 3'd0, 3'd5};
            9'h03D: pos = {1'b1, 3'd0, 3'd6};
            9'h03E: pos = {1'b1, 3'd0, 3'd7};
            // Row 1: 9, 0, A..E, Enter
            9'h046: pos = {1'b1, 3'd1, 3'd0};
            9'h045: pos = {1'b1, 3'd1, 3'd1};
            9'h01C: pos = {1'b1, 3'd1, 3'd2};
            9'h032: pos = {1'b1, 3'd1, 3'd3};
            9'h021: pos = {1'b1, 3'd1, 3'd4};
            9'h023: pos = {1'b1, 3'd1, 3'd5};
            9'h024: pos = {1'b1, 3'd1, 3'd6};
            9'h05A: pos = {1'b1, 3'd1, 3'd7};
            // Row 2: Space and the remaining keypad function keys
            9'h029: pos = {1'b1, 3'd2, 3'd0};
            9'h05D: pos = {1'b1, 3'd2, 3'd1};
            9'h07C: pos = {1'b1, 3'd2, 3'd2};
            // Row 6: cursor keys and Ctrl alias joystick 0
            9'h174: pos = {1'b1, 3'd6, 3'd0};
            9'h16B: pos = {1'b1, 3'd6, 3'd1};
            9'h172: pos = {1'b1, 3'd6, 3'd2};
            9'h175: pos = {1'b1, 3'd6, 3'd3};
            9'h014: pos = {1'b1, 3'd6, 3'd4};
            default: pos = '0;
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/myvision_hold_timer.sv
// Hold-tick divider and per-key press/release aging for the 64-key matrix.
// A release is stretched until the second tick after it, so short taps
// survive until the CPU scans the matrix.
module myvision_hold_timer
    import myvision_kbd_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ev_valid,
    input  logic        ev_press,
    input  logic [5:0]  ev_idx,
    output logic [63:0] key_st
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] tick_cnt_reg;
    logic             tick;
    logic [63:0]      st_reg;
    logic [63:0]      pend_reg;
    logic [63:0]      aged_reg;

    assign tick   = !reset && (tick_cnt_reg == CNT_LAST);
    assign key_st = st_reg;

    // Free-running divider, wraps at TICK_DIV-1.
    always_ff @(posedge clk_sys) begin
        if (reset || tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end

    for (genvar gi = 0; gi < 64; gi++) begin : g_key
        logic ev_here;
        assign ev_here = ev_valid && (ev_idx == 6'(gi));

        // Events win over the tick; a release keeps the pre-tick key state
        // and restarts aging from pend, so the key is never dropped early.
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                st_reg[gi]   <= 1'b0;
                pend_reg[gi] <= 1'b0;
                aged_reg[gi] <= 1'b0;
            end else if (ev_here && ev_press) begin
                st_reg[gi]   <= 1'b1;
                pend_reg[gi] <= 1'b0;
                aged_reg[gi] <= 1'b0;
            end else if (ev_here) begin
                pend_reg[gi] <= 1'b1;
                aged_reg[gi] <= tick ? 1'b0 : aged_reg[gi];
            end else if (tick) begin
                if (aged_reg[gi]) begin
                    st_reg[gi]   <= 1'b0;
                    pend_reg[gi] <= 1'b0;
                    aged_reg[gi] <= 1'b0;
                end else if (pend_reg[gi]) begin
                    aged_reg[gi] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/myvision_keymatrix.sv
// Host keyboard/joystick to MyVision key matrix: PS/2 event detect and
// lookup, joystick merge and the registered active-low column readback.
module myvision_keymatrix
    import myvision_kbd_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [31:0] joy0,
    input  logic [31:0] joy1,
    input  logic [7:0]  row_sel_n,
    output logic [7:0]  col_n
);

    logic        tog_q_reg;
    logic        ps2_event;
    key_pos_t    pos;
    logic [63:0] key_st;
    logic [63:0] eff;
    logic [7:0]  row_cols [8];
    logic [7:0]  col_any;
    logic [7:0]  col_n_reg;
    logic        unused_joy;

    assign unused_joy = &{1'b0, joy0[31:5], joy1[31:5]};

    // Toggle follower; tracking it during reset too means no event fires
    // on the first cycle out of reset.
    always_ff @(posedge clk_sys) begin
        tog_q_reg <= ps2_key[10];
    end

    assign ps2_event = (ps2_key[10] != tog_q_reg);
    assign pos       = ps2_to_pos({ps2_key[8], ps2_key[7:0]});

    myvision_hold_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_hold (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ev_valid (ps2_event && pos.hit),
        .ev_press (ps2_key[9]),
        .ev_idx   ({pos.row, pos.col}),
        .key_st   (key_st)
    );

    // Joysticks OR straight into their rows, with no hold stretching.
    always_comb begin
        eff = key_st;
        eff[JOY0_ROW*8 +: 5] = key_st[JOY0_ROW*8 +: 5] | joy0[4:0];
        eff[JOY1_ROW*8 +: 5] = key_st[JOY1_ROW*8 +: 5] | joy1[4:0];
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_row
        assign row_cols[gi] = row_sel_n[gi] ? 8'h00 : eff[gi*8 +: 8];
    end

    // Any selected row with a key down pulls its column low.
    always_comb begin
        col_any = 8'h00;
        for (int r = 0; r < 8; r++) begin
            col_any = col_any | row_cols[r];
        end
    end

    // Registered readback towards the PSG port.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            col_n_reg <= 8'hFF;
        end else begin
            col_n_reg <= ~col_any;
        end
    end

    assign col_n = col_n_reg;

endmodule

// File: tb/tb_myvision_keymatrix.sv
// Directed bench for myvision_keymatrix with a cycle-level reference model
// (per-key countdown of remaining hold ticks) checked every cycle, plus
// hand-computed expectations at key points.
module tb_myvision_keymatrix;

    localparam int TD = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [31:0] joy0;
    logic [31:0] joy1;
    logic [7:0]  row_sel_n;
    logic [7:0]  col_n;

    always #5 clk = ~clk;

    myvision_keymatrix #(.TICK_DIV(TD)) dut (
        .clk_sys   (clk),
        .reset     (reset),
        .ps2_key   (ps2_key),
        .joy0      (joy0),
        .joy1      (joy1),
        .row_sel_n (row_sel_n),
        .col_n     (col_n)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit          held [64];
    int          rel  [64];   // ticks left before a released key drops, -1 = none
    bit          pre  [64];
    int          mcnt;
    bit          mtog;
    bit          mvalid = 1'b0;
    logic [7:0]  exp_col;
    logic [63:0] m_eff;
    logic [7:0]  m_col;
    bit          m_tick;
    bit          m_ev;
    int          m_idx;

    function automatic int lookup(input logic [8:0] code);
        case (code)
            9'h016: return 0;    // r0c0
            9'h01E: return 1;    // r0c1
            9'h05A: return 15;   // r1c7
            9'h029: return 16;   // r2c0
            9'h175: return 51;   // r6c3
            default: return -1;
        endcase
    endfunction

    // Model: advances on each clock edge from the same inputs the DUT sees.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int k = 0; k < 64; k++) begin
                    held[k] = 1'b0;
                    rel[k]  = -1;
                end
                mcnt    = 0;
                mtog    = ps2_key[10];
                exp_col = 8'hFF;
                mvalid  = 1'b1;
            end else begin
                for (int k = 0; k < 64; k++) m_eff[k] = held[k];
                for (int c = 0; c < 5; c++) begin
                    m_eff[48+c] = m_eff[48+c] | joy0[c];
                    m_eff[56+c] = m_eff[56+c] | joy1[c];
                end
                m_col = 8'h00;
                for (int r = 0; r < 8; r++)
                    if (!row_sel_n[r]) m_col = m_col | m_eff[r*8 +: 8];
                exp_col = ~m_col;

                m_tick = (mcnt == TD - 1);
                mcnt   = m_tick ? 0 : mcnt + 1;
                m_ev   = (ps2_key[10] != mtog);
                mtog   = ps2_key[10];
                m_idx  = lookup({ps2_key[8], ps2_key[7:0]});

                for (int k = 0; k < 64; k++) pre[k] = held[k];
                if (m_tick) begin
                    for (int k = 0; k < 64; k++) begin
                        if (rel[k] >= 0) begin
                            rel[k] = rel[k] - 1;
                            if (rel[k] == 0) begin
                                held[k] = 1'b0;
                                rel[k]  = -1;
                            end
                        end
                    end
                end
                if (m_ev && m_idx >= 0) begin
                    if (ps2_key[9]) begin
                        held[m_idx] = 1'b1;
                        rel[m_idx]  = -1;
                    end else if (m_tick) begin
                        held[m_idx] = pre[m_idx];
                        rel[m_idx]  = 2;
                    end else if (rel[m_idx] < 0) begin
                        rel[m_idx] = 2;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mvalid) begin
                n_cmp++;
                if (col_n !== exp_col) begin
                    n_bad++;
                    $display("FAIL model_col t=%0t: col_n=%h expected=%h", $time, col_n, exp_col);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [7:0] exp);
        n_cmp++;
        if (col_n !== exp) begin
            n_bad++;
            $display("FAIL %s: col_n=%h expected=%h", name, col_n, exp);
        end else begin
            $display("ok   %s: col_n=%h", name, col_n);
        end
    endtask

    task automatic ps2(input logic press, input logic [8:0] code);
        ps2_key = {~ps2_key[10], press, code};
    endtask

    // Steps until the model's divider phase equals target (bounded).
    task automatic wait_phase(input int target);
        int guard;
        guard = 0;
        while (mcnt != target && guard < 4 * TD) begin
            step(1);
            guard++;
        end
        if (mcnt != target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL phase_timeout: phase=%0d expected=%0d", mcnt, target);
        end
    endtask

    initial begin
        reset     = 1'b1;
        ps2_key   = 11'h616;    // toggle high, '1' press code held through reset
        joy0      = '0;
        joy1      = '0;
        row_sel_n = 8'hFE;
        step(3);
        reset = 1'b0;
        step(3);
        check("reset_no_event", 8'hFF);

        // Press '1': visible exactly two cycles after the toggle
        ps2(1'b1, 9'h016);
        step(1);
        check("press_lat1", 8'hFF);
        step(1);
        check("press_lat2", 8'hFE);
        row_sel_n = 8'hFD;
        step(1);
        check("row_desel", 8'hFF);
        row_sel_n = 8'hFE;
        step(1);
        check("row_resel", 8'hFE);

        // Release: held for at least one full period, gone within two
        ps2(1'b0, 9'h016);
        step(TD + 1);
        check("rel_still_held", 8'hFE);
        step(TD + 2);
        check("rel_done", 8'hFF);

        // Short tap: press then release one cycle later
        ps2(1'b1, 9'h016);
        step(1);
        ps2(1'b0, 9'h016);
        step(2);
        check("tap_visible", 8'hFE);
        step(2 * TD + 2);
        check("tap_done", 8'hFF);

        // Re-press before the release matures keeps the key down
        ps2(1'b1, 9'h016);
        step(1);
        ps2(1'b0, 9'h016);
        step(1);
        ps2(1'b1, 9'h016);
        step(3 * TD);
        check("repress_hold", 8'hFE);
        ps2(1'b0, 9'h016);
        step(2 * TD + 4);
        check("repress_released", 8'hFF);

        // Joystick 1 fire on row 7, no stretching
        row_sel_n = 8'h7F;
        joy1 = 32'h10;
        step(1);
        check("joy1_fire", 8'hEF);
        joy1 = 32'h0;
        step(1);
        check("joy1_clear", 8'hFF);

        // Space (r2c0) OR joystick 0 right (r6c0)
        row_sel_n = 8'hBB;
        ps2(1'b1, 9'h029);
        joy0 = 32'h1;
        step(2);
        check("space_or_joy", 8'hFE);
        joy0 = 32'h0;
        step(1);
        check("space_only", 8'hFE);
        ps2(1'b1, 9'h0FF);
        step(2);
        check("unmapped", 8'hFE);
        ps2(1'b0, 9'h029);
        step(2 * TD + 4);
        check("space_released", 8'hFF);

        // Extended cursor up lands on the joystick-up position
        row_sel_n = 8'hBF;
        ps2(1'b1, 9'h175);
        step(2);
        check("e0_up", 8'hF7);
        ps2(1'b0, 9'h175);
        step(2 * TD + 4);
        check("e0_up_released", 8'hFF);

        // Press coincident with the tick that would drop an aged key
        row_sel_n = 8'hFE;
        ps2(1'b1, 9'h01E);
        step(1);
        wait_phase(0);
        ps2(1'b0, 9'h01E);
        wait_phase(TD - 1);
        step(1);                 // this tick ages the key
        wait_phase(TD - 1);
        ps2(1'b1, 9'h01E);       // lands on the next tick
        step(3 * TD);
        check("coinc_press", 8'hFD);

        // Release coincident with the tick on an aged key
        wait_phase(0);
        ps2(1'b0, 9'h01E);
        wait_phase(TD - 1);
        step(1);
        wait_phase(TD - 1);
        ps2(1'b0, 9'h01E);
        step(TD + 2);
        check("coinc_rel_hold", 8'hFD);
        step(TD);
        check("coinc_rel_done", 8'hFF);

        // Reset during a hold discards the pending release
        ps2(1'b1, 9'h016);
        step(2);
        ps2(1'b0, 9'h016);
        step(3);
        check("pre_reset_held", 8'hFE);
        reset = 1'b1;
        step(1);
        check("reset_mid_hold", 8'hFF);
        step(1);
        reset = 1'b0;
        step(3);
        check("after_reset", 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
